// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter and its one-hot encoder.
package arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oht_enc.sv
// One-hot to binary encoder built as a tree with fan-in SPLIT; idx is 0 for an all-zero input.
module oht_enc
  import arbiter_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int SPLIT     = 4,
  localparam int WIDTH_LOG = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 vld
);

  if (WIDTH <= SPLIT) begin : g_leaf
    always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (oht[i]) idx = idx | WIDTH_LOG'(i);
      end
    end
    assign vld = |oht;
  end else begin : g_tree
    // Power-of-two groups let the group number and in-group index concatenate.
    localparam int GRP_IN  = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int SUB_LOG = $clog2(GRP_IN);
    localparam int GRP     = 1 << SUB_LOG;
    localparam int NGRP    = (WIDTH + GRP - 1) / GRP;
    localparam int PAD     = NGRP * GRP;
    localparam int GRP_LOG = idx_width(NGRP);

    logic [PAD-1:0]             padded;
    logic [SUB_LOG-1:0]         sub_idx [NGRP];
    logic [NGRP-1:0]            grp_vld;
    logic [SUB_LOG-1:0]         sub_or;
    logic [GRP_LOG-1:0]         grp_idx;
    logic [GRP_LOG+SUB_LOG-1:0] full_idx;

    assign padded = PAD'(oht);

    for (genvar g = 0; g < NGRP; g++) begin : g_sub
      oht_enc #(.WIDTH(GRP), .SPLIT(SPLIT)) u_sub (
        .oht (padded[g*GRP +: GRP]),
        .idx (sub_idx[g]),
        .vld (grp_vld[g])
      );
    end

    // Idle groups report index 0, so OR-merging keeps only the active one.
    always_comb begin
      sub_or = '0;
      for (int g = 0; g < NGRP; g++) sub_or = sub_or | sub_idx[g];
    end

    oht_enc #(.WIDTH(NGRP), .SPLIT(SPLIT)) u_grp (
      .oht (grp_vld),
      .idx (grp_idx),
      .vld (vld)
    );

    assign full_idx = {grp_idx, sub_or};
    assign idx      = WIDTH_LOG'(full_idx);
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first request strictly above ptr, else wrap to the lowest request.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int SPLIT     = 4,
  localparam int WIDTH_LOG = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH_LOG-1:0] ptr,
  output logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 vld
);

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] hi_lsb;
  logic [WIDTH-1:0] all_lsb;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) mask[i] = (i > int'(ptr));
  end

  // x & -x isolates the lowest set bit.
  assign hi      = req & mask;
  assign hi_lsb  = hi & (-hi);
  assign all_lsb = req & (-req);
  assign oht     = (|hi) ? hi_lsb : all_lsb;

  oht_enc #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_enc (
    .oht (oht),
    .idx (idx),
    .vld (vld)
  );

endmodule

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter: one-hot grant plus index, back-to-back grants on transfer.
module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int SPLIT     = 4,
  localparam int WIDTH_LOG = idx_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req_vld,
  output logic [WIDTH-1:0]     req_rdy,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy,
  output logic [WIDTH-1:0]     gnt_oht,
  output logic [WIDTH_LOG-1:0] gnt_idx
);

  arb_state_e           state, state_nxt;
  logic [WIDTH_LOG-1:0] ptr, ptr_nxt, pick_ptr, pick_idx, gnt_idx_nxt;
  logic [WIDTH-1:0]     pick_oht, gnt_oht_nxt;
  logic                 pick_vld, xfer, held;

  assign xfer    = gnt_vld & gnt_rdy;
  assign held    = |(req_vld & gnt_oht);
  assign gnt_vld = (state == GRANT);
  assign req_rdy = gnt_oht & {WIDTH{xfer}};

  // A transfer re-arbitrates in the same cycle with the just-served index as last-served.
  assign pick_ptr = xfer ? gnt_idx : ptr;

  rr_pick #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_pick (
    .req (req_vld),
    .ptr (pick_ptr),
    .oht (pick_oht),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_oht_nxt = gnt_oht;
    gnt_idx_nxt = gnt_idx;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt   = GRANT;
          gnt_oht_nxt = pick_oht;
          gnt_idx_nxt = pick_idx;
        end
      end
      GRANT: begin
        if (xfer) begin
          ptr_nxt = gnt_idx;
          if (pick_vld) begin
            gnt_oht_nxt = pick_oht;
            gnt_idx_nxt = pick_idx;
          end else begin
            state_nxt   = IDLE;
            gnt_oht_nxt = '0;
            gnt_idx_nxt = '0;
          end
        end else if (!held) begin
          // Withdrawal: drop the grant but keep the priority order untouched.
          state_nxt   = IDLE;
          gnt_oht_nxt = '0;
          gnt_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        gnt_oht_nxt = '0;
        gnt_idx_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: reset wins over any handshake in the same cycle, so a late gnt_rdy never moves ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= WIDTH_LOG'(WIDTH - 1);
      gnt_oht <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_oht <= gnt_oht_nxt;
      gnt_idx <= gnt_idx_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: directed scenarios plus random traffic against a rotation model.
module tb_round_robin_arbiter;

  localparam int W  = 16;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  req_vld = '0;
  logic [W-1:0]  req_rdy;
  logic          gnt_vld;
  logic          gnt_rdy = 1'b0;
  logic [W-1:0]  gnt_oht;
  logic [WL-1:0] gnt_idx;

  int total = 0;
  int bad   = 0;

  // Reference model: last-served pointer and current grant.
  int m_ptr = W - 1;
  bit m_vld = 1'b0;
  int m_idx = 0;

  always #5 clk = ~clk;

  round_robin_arbiter #(.WIDTH(W), .SPLIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy),
    .gnt_oht (gnt_oht),
    .gnt_idx (gnt_idx)
  );

  // Walk the requesters in rotation order starting just after p; p itself is visited last.
  function automatic int rr_winner(input logic [W-1:0] r, input int p);
    for (int k = 1; k <= W; k++) begin
      int c;
      c = (p + k) % W;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [2*W+2*WL:0] obs();
    return {gnt_vld, gnt_idx, gnt_oht, req_rdy, dut.ptr};
  endfunction

  function automatic logic [2*W+2*WL:0] expv();
    logic [W-1:0]  o;
    logic [W-1:0]  rdy;
    logic [WL-1:0] i;
    logic [WL-1:0] p;
    o   = m_vld ? (W'(1) << m_idx) : {W{1'b0}};
    rdy = (m_vld && gnt_rdy) ? o : {W{1'b0}};
    i   = WL'(m_idx);
    p   = WL'(m_ptr);
    return {m_vld, i, o, rdy, p};
  endfunction

  // One clock edge; the model advances from the inputs held across that edge.
  task automatic step();
    int w;
    @(posedge clk);
    if (rst) begin
      m_ptr = W - 1;
      m_vld = 1'b0;
      m_idx = 0;
    end else if (!m_vld) begin
      w = rr_winner(req_vld, m_ptr);
      if (w >= 0) begin
        m_vld = 1'b1;
        m_idx = w;
      end
    end else if (gnt_rdy) begin
      m_ptr = m_idx;
      w = rr_winner(req_vld, m_ptr);
      if (w >= 0) m_idx = w;
      else begin
        m_vld = 1'b0;
        m_idx = 0;
      end
    end else if (!req_vld[m_idx]) begin
      m_vld = 1'b0;
      m_idx = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0; gnt_rdy = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_vld = '0; gnt_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
    total++;
    if (obs() !== expv()) begin
      bad++; $display("FAIL reset_model: got %h want %h", obs(), expv());
    end
    total++;
    if ({gnt_vld, gnt_idx, gnt_oht, dut.ptr} !== {1'b0, 4'd0, 16'h0000, 4'd15}) begin
      bad++; $display("FAIL reset_values: got vld=%b idx=%0d oht=%h ptr=%0d want 0/0/0000/15",
                      gnt_vld, gnt_idx, gnt_oht, dut.ptr);
    end
  endtask

  task automatic test_single();
    req_vld = 16'h0010; gnt_rdy = 1'b0;
    step();
    total++;
    if ({gnt_vld, gnt_idx, gnt_oht} !== {1'b1, 4'd4, 16'h0010}) begin
      bad++; $display("FAIL single_grant: got vld=%b idx=%0d oht=%h want 1/4/0010", gnt_vld, gnt_idx, gnt_oht);
    end
    gnt_rdy = 1'b1;
    #1;
    total++;
    if (req_rdy !== 16'h0010) begin
      bad++; $display("FAIL single_req_rdy: got %h want 0010", req_rdy);
    end
    req_vld = '0;
    step();
    total++;
    if (dut.ptr !== 4'd4 || gnt_vld !== 1'b0) begin
      bad++; $display("FAIL single_after: got ptr=%0d vld=%b want 4/0", dut.ptr, gnt_vld);
    end
    total++;
    if (obs() !== expv()) begin
      bad++; $display("FAIL single_model: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req_vld = 16'hFFFF; gnt_rdy = 1'b1;
    step();
    for (int k = 0; k <= W; k++) begin
      total++;
      if (gnt_vld !== 1'b1 || gnt_idx !== WL'(k % W)) begin
        bad++; $display("FAIL fairness_seq: step %0d got vld=%b idx=%0d want 1/%0d", k, gnt_vld, gnt_idx, k % W);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_vld = 16'h0006; gnt_rdy = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (gnt_idx !== 4'd1 || gnt_vld !== 1'b1 || req_rdy !== 16'h0000) begin
        bad++; $display("FAIL backpressure_hold: cycle %0d got idx=%0d vld=%b req_rdy=%h want 1/1/0000",
                        k, gnt_idx, gnt_vld, req_rdy);
      end
      step();
    end
    gnt_rdy = 1'b1;
    #1;
    total++;
    if (req_rdy !== 16'h0002) begin
      bad++; $display("FAIL backpressure_xfer: got req_rdy=%h want 0002", req_rdy);
    end
    step();
    total++;
    if (gnt_idx !== 4'd2 || gnt_vld !== 1'b1) begin
      bad++; $display("FAIL backpressure_next: got idx=%0d vld=%b want 2/1", gnt_idx, gnt_vld);
    end
  endtask

  task automatic test_wrap();
    int exp_seq [6] = '{0, 15, 0, 3, 3, 3};
    do_reset();
    req_vld = 16'h8001; gnt_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) req_vld = 16'h0008;
      step();
      total++;
      if (gnt_vld !== 1'b1 || gnt_idx !== WL'(exp_seq[k])) begin
        bad++; $display("FAIL wrap_seq: step %0d got vld=%b idx=%0d want 1/%0d", k, gnt_vld, gnt_idx, exp_seq[k]);
      end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req_vld = 16'h0020; gnt_rdy = 1'b0;
    step();
    total++;
    if (gnt_idx !== 4'd5 || gnt_vld !== 1'b1) begin
      bad++; $display("FAIL withdraw_grant: got idx=%0d vld=%b want 5/1", gnt_idx, gnt_vld);
    end
    req_vld = 16'h0050;
    step();
    total++;
    if (gnt_vld !== 1'b0 || gnt_oht !== 16'h0000 || dut.ptr !== 4'd15) begin
      bad++; $display("FAIL withdraw_drop: got vld=%b oht=%h ptr=%0d want 0/0000/15", gnt_vld, gnt_oht, dut.ptr);
    end
    step();
    total++;
    if (gnt_idx !== 4'd4 || gnt_vld !== 1'b1) begin
      bad++; $display("FAIL withdraw_regrant: got idx=%0d vld=%b want 4/1", gnt_idx, gnt_vld);
    end
  endtask

  task automatic test_reset_mid();
    req_vld = 16'hFFFF; gnt_rdy = 1'b1;
    step();
    total++;
    if (gnt_vld !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre: got vld=%b want 1", gnt_vld);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({gnt_vld, gnt_idx, gnt_oht, dut.ptr} !== {1'b0, 4'd0, 16'h0000, 4'd15}) begin
      bad++; $display("FAIL reset_mid_clear: got vld=%b idx=%0d oht=%h ptr=%0d want 0/0/0000/15",
                      gnt_vld, gnt_idx, gnt_oht, dut.ptr);
    end
    step();
    total++;
    if (gnt_idx !== 4'd0 || gnt_vld !== 1'b1) begin
      bad++; $display("FAIL reset_mid_first: got idx=%0d vld=%b want 0/1", gnt_idx, gnt_vld);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0:       req_vld = W'($urandom);
        1:       req_vld = W'($urandom & $urandom & $urandom);
        2:       req_vld = W'(1) << $urandom_range(0, W - 1);
        default: if ($urandom_range(0, 3) == 0) req_vld = '0;
      endcase
      gnt_rdy = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 59) == 0);
      #1;
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL random_model: cycle %0d got %h want %h", k, obs(), expv());
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Registered round-robin arbiter that shares one downstream consumer among `WIDTH` requesters. Each cycle it selects the next requester after the last served one and presents the winner as a one-hot grant plus a binary index. Grant selection uses the team's one-hot encoding primitives. The block sits in front of any shared resource port, for example a shared encoder or bus slave, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 16: number of requesters; must be ≥ 2, any value.
- `SPLIT`, default 4: tree split factor passed to the internal one-hot encoder.
- `WIDTH_LOG`, localparam `$clog2(WIDTH)`: index width.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `req_vld`  in  WIDTH: per-requester request.
- `req_rdy`  out  WIDTH: per-requester acknowledge; combinational.
- `gnt_vld`  out  1: grant valid; registered.
- `gnt_rdy`  in  1: downstream accepts the granted transfer.
- `gnt_oht`  out  WIDTH: one-hot grant; registered; all zero when `gnt_vld`=0.
- `gnt_idx`  out  WIDTH_LOG: binary index of `gnt_oht`; registered; 0 when idle.

## Operation
- State machine `IDLE` / `GRANT`.
- **`IDLE`:** if `|req_vld`, arbitrate, load `gnt_oht`/`gnt_idx`, set `gnt_vld`, go to `GRANT`. Otherwise stay.
- **`GRANT`:** the grant is held stable until a transfer or a withdrawal.
  - Transfer: `gnt_vld & gnt_rdy`. On transfer, `ptr <= gnt_idx`. In the same cycle, re-arbitrate on current `req_vld` using the new priority order.
    - If any request remains, stay in `GRANT` with the new winner. This gives back-to-back grants with no bubble.
    - If no request remains, go to `IDLE`.
  - Withdrawal: `req_vld[gnt_idx]`=0 without a transfer. Drop the grant next cycle: `gnt_vld`=0, go to `IDLE`, `ptr` unchanged. A transfer in that same cycle takes precedence.
- **Arbitration:**
  - `ptr` is the last-served index.
  - `mask` = bits strictly above `ptr`.
  - If `req_vld & mask` is non-zero, the winner is its lowest set bit. Otherwise the winner is the lowest set bit of `req_vld` (wrap-around).
  - The last-served requester therefore has lowest priority, but is re-granted if it is the sole requester.
- `req_rdy = gnt_oht & {WIDTH{gnt_vld & gnt_rdy}}`.
- **Reset values:**
  - `ptr` = WIDTH-1, so requester 0 has highest priority first.
  - State `IDLE`, `gnt_vld`=0, `gnt_oht`=0, `gnt_idx`=0.
- **Reset mid-grant:** outputs clear on the next edge and no transfer is counted. A `gnt_rdy` sampled in that same cycle is ignored for `ptr`.

## Timing
- Request-to-grant latency is 1 cycle: `req_vld` sampled at edge N, `gnt_vld` high after edge N.
- Throughput is one transfer per cycle with continuous requests and `gnt_rdy`=1.
- `gnt_oht` and `gnt_idx` never change while `gnt_vld`=1 and `gnt_rdy`=0, unless a withdrawal occurs.
- `req_rdy` is the only combinational path (`gnt_rdy` → `req_rdy`). No path from `req_vld` reaches any output in the same cycle.
- **Invariants:**
  - `$onehot0(gnt_oht)` always holds.
  - `gnt_vld == |gnt_oht`.
  - `gnt_idx` is consistent with `gnt_oht` whenever `gnt_vld`=1.

## Structure
- Package `arbiter_pkg`: state enum typedef (`IDLE`, `GRANT`) and a function for the index width (`$clog2` with a minimum of 1).
- One sub-module, `rr_pick` (combinational):
  - Inputs: `req`, `ptr`. Outputs: `oht`, `idx`, `vld`.
  - Implements the masking, the two lowest-set-bit selections and the merge.
  - `idx` is produced by the existing one-hot encoder tree (`WIDTH`, `SPLIT`).
- Top level holds the FSM, the `ptr` register and the grant registers.

## Test plan
- **Single request:** after reset, `req_vld`=16'h0010 → next cycle `gnt_vld`=1, `gnt_idx`=4, `gnt_oht`=16'h0010. With `gnt_rdy`=1: `req_rdy`=16'h0010, `ptr`=4.
- **Fairness:** `req_vld`=16'hFFFF held, `gnt_rdy`=1 → grants 0,1,2,…,15,0 in consecutive cycles with no bubble.
- **Backpressure:** `req_vld`=16'h0006, `gnt_rdy`=0 for 5 cycles → `gnt_idx`=1 stable and `req_rdy`=0 throughout. Then `gnt_rdy`=1 → transfer of 1, next grant 2.
- **Wrap and sole-requester regrant:**
  - `ptr`=15 with `req_vld`=16'h8001 → grant 0, then 15, then 0.
  - `req_vld`=16'h0008 alone → grant 3 repeatedly.
- **Withdrawal:** granted index 5, `req_vld[5]` drops with `gnt_rdy`=0 → next cycle `gnt_vld`=0, `ptr` unchanged. The following grant is computed from the old `ptr`.
- **Reset mid-grant:** `rst`=1 while `gnt_vld`=1, `gnt_rdy`=1 → next cycle all outputs 0 and `ptr`=15. The first post-reset grant with `req_vld`=16'hFFFF is index 0.
